// File: rtl/md_sequencer.sv
// md_sequencer: sequences the shared multiply/divide units and the Hi/Lo
// register writes on behalf of the main control unit.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   start_mult  one-cycle mult request (accepted only in IDLE)
//   start_div   one-cycle div request (accepted only in IDLE; mult wins)
//   md_abort    flush the operation in flight, no Hi/Lo write
//   div_end     divide unit finished
//   div_zero    divide unit reports divisor == 0
//   mult_ctrl   mult unit start pulse
//   div_ctrl    div unit start pulse
//   MDSelect    Hi/Lo source select, 1 = mult result, 0 = div result
//   HiCtrl      Hi write enable
//   LoCtrl      Lo write enable
//   md_busy     operation in flight, control unit stalls
//   md_done     one-cycle pulse, Hi/Lo hold the new result
//   md_excpt    one-cycle pulse, divide by zero or timeout
//   md_timeout  qualifies md_excpt: 1 = timeout, 0 = divide by zero
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 33,
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic md_abort,
  input  logic div_end,
  input  logic div_zero,
  output logic mult_ctrl,
  output logic div_ctrl,
  output logic MDSelect,
  output logic HiCtrl,
  output logic LoCtrl,
  output logic md_busy,
  output logic md_done,
  output logic md_excpt,
  output logic md_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    M_START,
    M_RUN,
    D_START,
    D_RUN,
    WRITE,
    DONE,
    EXC
  } state_t;

  localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_TIMEOUT - 1);

  state_t     state, next_state;
  logic [5:0] cnt, cnt_next;
  logic       sel_q, sel_next;
  logic       to_q, to_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sel_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      sel_q <= sel_next;
      to_q  <= to_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    sel_next   = sel_q;
    to_next    = to_q;
    case (state)
      IDLE: begin
        to_next = 1'b0;
        // The select register is loaded on acceptance so that its new value
        // is already visible during the start-state cycle.
        if (start_mult) begin
          next_state = M_START;
          sel_next   = 1'b1;
        end else if (start_div) begin
          next_state = D_START;
          sel_next   = 1'b0;
        end
      end
      M_START: begin
        cnt_next   = '0;
        next_state = M_RUN;
      end
      M_RUN: begin
        cnt_next = cnt + 6'd1;
        if (cnt == MULT_LAST) next_state = WRITE;
      end
      D_START: begin
        cnt_next   = '0;
        next_state = D_RUN;
      end
      D_RUN: begin
        cnt_next = cnt + 6'd1;
        if (div_zero) begin
          next_state = EXC;
          to_next    = 1'b0;
        end else if (div_end) begin
          next_state = WRITE;
        end else if (cnt == DIV_LAST) begin
          next_state = EXC;
          to_next    = 1'b1;
        end
      end
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      EXC:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Abort overrides every transition out of a busy state; a WRITE cycle
    // already in progress still completes since its enables are decoded
    // from the current state.
    if (state != IDLE && md_abort) next_state = IDLE;
  end

  always_comb begin
    mult_ctrl  = (state == M_START);
    div_ctrl   = (state == D_START);
    MDSelect   = sel_q;
    HiCtrl     = (state == WRITE);
    LoCtrl     = (state == WRITE);
    md_busy    = (state != IDLE);
    md_done    = (state == DONE);
    md_excpt   = (state == EXC);
    md_timeout = (state == EXC) && to_q;
  end

endmodule
